mem_2p: RTL
===========

MEM_2P -- requirements
Module: mem_2p

Interface
REQ-001 SHALL have parameter DW, default 4, data word width in bits.
REQ-002 SHALL have parameter AW, default 4, address width in bits; DEPTH = 2**AW words.
REQ-003 SHALL have parameter WR_FIRST, default 0, same-address collision mode (0 read-first, 1 write-first).
REQ-004 SHALL have port clk  in  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port clr  in  1  request a full-array clear sweep.
REQ-007 SHALL have port we  in  1  write enable.
REQ-008 SHALL have port waddr  in  AW  write address.
REQ-009 SHALL have port wdata  in  DW  write data.
REQ-010 SHALL have port re  in  1  read enable.
REQ-011 SHALL have port raddr  in  AW  read address.
REQ-012 SHALL have port rdata  out  DW  registered read data.
REQ-013 SHALL have port rvalid  out  1  rdata carries a new read result this cycle.
REQ-014 SHALL have port busy  out  1  clear sweep in progress; we, re, clr ignored.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR (sweep) and RUN (normal access).
REQ-016 In CLEAR, SHALL write 0 to address cnt each cycle, cnt counting 0..DEPTH-1, one word per cycle.
REQ-017 SHALL move CLEAR->RUN in the cycle after writing address DEPTH-1; busy=1 exactly while in CLEAR.
REQ-018 In RUN, clr=1 SHALL move to CLEAR with cnt=0; we/re asserted in that same cycle are still serviced.
REQ-019 In RUN, we=1 SHALL write wdata to mem[waddr] at the clock edge.
REQ-020 In RUN, re=1 at edge t SHALL present mem[raddr] on rdata with rvalid=1 after edge t (latency 1).
REQ-021 rvalid SHALL be 0 in any cycle following an edge without an accepted read; rdata SHALL then hold its last value.
REQ-022 On we=1, re=1, waddr==raddr: WR_FIRST=0 SHALL return the old word; WR_FIRST=1 SHALL return wdata.
REQ-023 Reads and writes to different addresses in the same cycle SHALL both complete, no stall.
REQ-024 In CLEAR, we, re and clr SHALL have no effect; rvalid SHALL stay 0.
REQ-025 cnt SHALL be AW+1 bits wide, or use an explicit last-address compare, so the DEPTH-1 terminal count never wraps silently.

Reset
REQ-026 While rst=1: state=CLEAR, cnt=0, rdata=0, rvalid=0, busy=1; no array write occurs.
REQ-027 The first edge with rst=0 SHALL clear address 0; busy SHALL fall DEPTH cycles after rst deasserts.
REQ-028 rst asserted mid-sweep or mid-access SHALL restart the sweep at address 0; in-flight reads are dropped (rvalid=0).

Structure
REQ-029 FSM state encoding and the collision-mode constants SHALL live in the shared package mem_pkg.
REQ-030 The storage array SHALL be a separate sub-module mem_2p_array (one write port, one registered read port, WR_FIRST bypass); mem_2p holds the FSM, counter and port muxing.

Verification
REQ-031 Reset release, DW=4, AW=4: busy=1 for 16 cycles, then 0; reads of all 16 addresses return 0.
REQ-032 Write addr 3 = 8, next cycle re addr 3: one cycle later rdata=8, rvalid=1; the following idle cycle has rvalid=0 and rdata=8.
REQ-033 addr 3 holds 8; we=1 wdata=15 and re=1 on addr 3 in the same cycle: WR_FIRST=0 returns 8, WR_FIRST=1 returns 15; a later read returns 15.
REQ-034 Write addr 5 = 9 while reading addr 3 in the same cycle: rdata=addr 3 contents; a later read of addr 5 returns 9.
REQ-035 clr pulse with addr 3 = 8 stored: busy=1 for 16 cycles, we=1 to addr 7 during the sweep is ignored, then addr 3 and addr 7 read 0.
REQ-036 rst asserted at sweep cycle 6 for one cycle: sweep restarts at 0; busy falls 16 cycles after rst release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the two-port memory with clear sweep.
// Holds the FSM encoding and the same-address collision modes.
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int COLL_READ_FIRST  = 0;
    localparam int COLL_WRITE_FIRST = 1;

endpackage

// File: rtl/mem_2p_array.sv
// Storage array: one write port, one registered read port.
// Optional write-first bypass on same-address collisions.
module mem_2p_array
    import mem_pkg::*;
#(
    parameter int DW       = 4,
    parameter int AW       = 4,
    parameter int WR_FIRST = COLL_READ_FIRST
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic          hit;

    assign hit = we && (waddr == raddr);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking array update means a plain read returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            if ((WR_FIRST == COLL_WRITE_FIRST) && hit) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/mem_2p.sv
// Two-port memory with a full-array clear sweep after reset or clr.
// Holds the sweep FSM, the address counter and the array port muxing.
module mem_2p
    import mem_pkg::*;
#(
    parameter int DW       = 4,
    parameter int AW       = 4,
    parameter int WR_FIRST = COLL_READ_FIRST
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          busy
);

    localparam int          DEPTH = 1 << AW;
    localparam logic [AW:0] LAST  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE   = (AW+1)'(1);

    state_t        state;
    state_t        state_n;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_n;
    logic          a_we;
    logic [AW-1:0] a_waddr;
    logic [DW-1:0] a_wdata;
    logic          a_re;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_CLEAR;
            cnt    <= '0;
            rvalid <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rvalid <= a_re;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_we    = 1'b0;
        a_waddr = waddr;
        a_wdata = wdata;
        a_re    = 1'b0;
        busy    = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                busy    = 1'b1;
                a_we    = 1'b1;
                a_waddr = cnt[AW-1:0];
                a_wdata = '0;
                if (cnt == LAST) begin
                    state_n = ST_RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            ST_RUN: begin
                a_we = we;
                a_re = re;
                if (clr) begin
                    state_n = ST_CLEAR;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = ST_CLEAR;
                cnt_n   = '0;
            end
        endcase
        // Reset blocks array traffic and drops any read in flight.
        if (rst) begin
            a_we = 1'b0;
            a_re = 1'b0;
        end
    end

    mem_2p_array #(
        .DW       (DW),
        .AW       (AW),
        .WR_FIRST (WR_FIRST)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (a_we),
        .waddr (a_waddr),
        .wdata (a_wdata),
        .re    (a_re),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule
